// File: rtl/apb_mem_pkg.sv
// -----------------------------------------------------------------------------
// apb_mem_pkg
// Shared definitions for the APB3 memory slave: FSM state encoding, default
// parameter values and the wait-counter width.
// -----------------------------------------------------------------------------
package apb_mem_pkg;

  // Default configuration of apb_mem_slave
  localparam int DEF_ADDR_W      = 8;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_DEPTH       = 256;
  localparam int DEF_WAIT_STATES = 0;

  // Wait counter width; covers WAIT_STATES 0..15
  localparam int WCNT_W = 4;

  // Transfer FSM
  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  // Index width for a storage of the given depth (at least one bit)
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/apb_mem_slave_array.sv
// -----------------------------------------------------------------------------
// apb_mem_slave_array
// DEPTH x DATA_W word storage with a synchronous byte-enabled write port and an
// asynchronous read port sharing one address. Contents are not reset.
//
// Ports:
//   clk    in   write clock (rising edge)
//   we     in   write enable
//   be     in   DATA_W/8 byte-lane enables, qualified by we
//   addr   in   IDX_W word index (read and write)
//   wdata  in   DATA_W write data
//   rdata  out  DATA_W combinational read data of mem[addr]
// -----------------------------------------------------------------------------
module apb_mem_slave_array
  import apb_mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int IDX_W  = idx_width(DEF_DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [IDX_W-1:0]      addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  // Byte-lane write port; only enabled lanes are updated
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < NB; b++) begin
        if (be[b]) begin
          mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  // Asynchronous read; the top only consumes it for in-range addresses
  assign rdata = mem[addr];

endmodule

// File: rtl/apb_mem_slave.sv
// -----------------------------------------------------------------------------
// apb_mem_slave
// Parametrised APB3 memory-mapped slave with programmable wait states, a
// registered read path and PSLVERR on out-of-range word addresses.
//
// Build option: define APB_MEM_PSTRB_EN to add the PSTRB port and byte-lane
// write masking. Without it every write updates the whole word.
//
// Parameters:
//   ADDR_W       PADDR width (word index)
//   DATA_W       data width, multiple of 8, 8..64
//   DEPTH        number of words, DEPTH <= 2**ADDR_W
//   WAIT_STATES  PREADY-low access cycles per transfer, 0..15
//
// Ports:
//   PCLK     in   clock, rising edge
//   PRESETn  in   asynchronous active-low reset
//   PSEL     in   slave select
//   PENABLE  in   access phase
//   PWRITE   in   1 = write, 0 = read
//   PADDR    in   word address
//   PWDATA   in   write data
//   PSTRB    in   byte-lane write enables (APB_MEM_PSTRB_EN only)
//   PRDATA   out  registered read data, held until the next read setup
//   PREADY   out  transfer completion, decoded from registers
//   PSLVERR  out  error response, only while PREADY=1
// -----------------------------------------------------------------------------
module apb_mem_slave
  import apb_mem_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int WAIT_STATES = DEF_WAIT_STATES
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic                PSEL,
  input  logic                PENABLE,
  input  logic                PWRITE,
  input  logic [ADDR_W-1:0]   PADDR,
  input  logic [DATA_W-1:0]   PWDATA,
`ifdef APB_MEM_PSTRB_EN
  input  logic [DATA_W/8-1:0] PSTRB,
`endif
  output logic [DATA_W-1:0]   PRDATA,
  output logic                PREADY,
  output logic                PSLVERR
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = idx_width(DEPTH);
  localparam logic [WCNT_W-1:0] WCNT_INIT = WCNT_W'(WAIT_STATES);
  localparam logic [WCNT_W-1:0] WCNT_ONE  = {{(WCNT_W-1){1'b0}}, 1'b1};
  localparam logic [WCNT_W-1:0] WCNT_ZERO = {WCNT_W{1'b0}};

  state_e              state_q,  state_d;
  logic [WCNT_W-1:0]   wcnt_q,   wcnt_d;
  logic                err_q,    err_d;
  logic [DATA_W-1:0]   prdata_q, prdata_d;

  logic                in_range_s;
  logic [IDX_W-1:0]    idx_s;
  logic [DATA_W-1:0]   rd_data_s;
  logic                wr_en_s;
  logic [NB-1:0]       byte_en_s;

  // Only the low index bits address storage; in_range_s guards their use
  assign in_range_s = (64'(PADDR) < 64'(DEPTH));
  assign idx_s      = PADDR[IDX_W-1:0];

`ifdef APB_MEM_PSTRB_EN
  assign byte_en_s = PSTRB;
`else
  assign byte_en_s = {NB{1'b1}};
`endif

  apb_mem_slave_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk   (PCLK),
    .we    (wr_en_s),
    .be    (byte_en_s),
    .addr  (idx_s),
    .wdata (PWDATA),
    .rdata (rd_data_s)
  );

  // Next-state, wait counter, error flag and read capture
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    err_d    = err_q;
    prdata_d = prdata_q;
    wr_en_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          state_d = ACCESS;
          wcnt_d  = WCNT_INIT;
          err_d   = !in_range_s;
          // Read data is captured at the setup edge so it is valid for the
          // whole access phase; writes leave the last read value in place.
          if (!PWRITE) begin
            prdata_d = in_range_s ? rd_data_s : {DATA_W{1'b0}};
          end else begin
            prdata_d = prdata_q;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (!PSEL) begin
          // Master abandoned the transfer: nothing is committed
          state_d = IDLE;
        end else if (PENABLE) begin
          if (wcnt_q == WCNT_ZERO) begin
            state_d = IDLE;
            wr_en_s = PWRITE && !err_q;
          end else begin
            wcnt_d = wcnt_q - WCNT_ONE;
          end
        end else begin
          state_d = ACCESS;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and read-data registers
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= IDLE;
      wcnt_q   <= WCNT_ZERO;
      err_q    <= 1'b0;
      prdata_q <= {DATA_W{1'b0}};
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      err_q    <= err_d;
      prdata_q <= prdata_d;
    end
  end

  assign PREADY  = (state_q == ACCESS) && (wcnt_q == WCNT_ZERO);
  assign PSLVERR = PREADY && err_q;
  assign PRDATA  = prdata_q;

endmodule
